// File: rtl/iter_divider_if.sv
// Request/result bundle between the EX stage (master) and the iterative divider (slave).
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// Restoring divider, one quotient bit per clock, for DIV/DIVU/REM/REMU.
// busy/done are registered from the current state, so they trail the FSM by one cycle.
module iter_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff_ext;
  logic             borrow;

  always_comb begin
    accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    dvd_abs  = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    dsr_abs  = (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    rem_sh   = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    diff_ext = {1'b0, rem_sh} - {1'b0, dsr_q};
    borrow   = diff_ext[WIDTH];

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;
    busy_d   = (state_q == CALC) || (state_q == FIX);
    done_d   = (state_q == DONE);

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d   = '0;
          dsr_d   = dsr_abs;
          q_neg_d = bus.signed_op && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          r_neg_d = bus.signed_op && bus.dividend[WIDTH-1];
          if (bus.divisor == '0) begin
            // Park the raw dividend in rem so FIX can return it untouched.
            state_d = FIX;
            rem_d   = bus.dividend;
            dvd_d   = '0;
          end else begin
            state_d = CALC;
            rem_d   = '0;
            dvd_d   = dvd_abs;
          end
        end
      end
      CALC: begin
        // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
        rem_d = borrow ? rem_sh : diff_ext[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        if (dsr_q == '0) begin
          quo_d = '1;
          rmd_d = rem_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_neg_q ? -dvd_q : dvd_q;
          rmd_d = r_neg_q ? -rem_q : rem_q;
          dbz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Multi-cycle restoring integer divider for the EX stage of the pipelined RISC core. It serves DIV/DIVU/REM/REMU and produces one quotient bit per clock. Each bit comes from a (WIDTH+1)-bit trial subtraction whose borrow (MSB of the extended difference) decides restore vs. keep. The hazard unit stalls the pipeline while busy is high and resumes on the done pulse.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
signed_op  input  1  1 = two's-complement operands, 0 = unsigned
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  result, held until the next accepted start completes
remainder  output  WIDTH  result, held likewise
div_by_zero  output  1  flag for last operation, held with results

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset mid-operation aborts immediately. No done pulse is issued and outputs return to reset values.
- States and transitions:
  - IDLE -> CALC on accepted start with divisor!=0.
  - IDLE -> FIX on accepted start with divisor==0.
  - CALC stays for exactly WIDTH cycles, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE, or -> CALC/FIX directly if start=1 in DONE (back-to-back).
- Accept rule: start is accepted when state is IDLE or DONE. It is ignored in CALC/FIX, with no queueing and no effect on the running operation.
- Operand capture on accept:
  - signed_op=1: store magnitudes |dividend| and |divisor|, plus q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend).
  - signed_op=0: store operands as-is; q_neg=r_neg=0.
- CALC step, MSB first:
  - rem' = {rem[WIDTH-2:0], dvd_msb}.
  - {borrow, diff} = {1'b0, rem'} - {1'b0, divisor}, a (WIDTH+1)-bit subtraction.
  - borrow=0: rem <= diff[WIDTH-1:0], q bit = 1.
  - borrow=1: rem <= rem', q bit = 0.
- FIX (one cycle):
  - Negate quotient if q_neg; negate remainder if r_neg.
  - Divide by zero: quotient = all ones; remainder = original dividend (unmodified, either mode); div_by_zero=1.
  - Signed overflow (dividend = -2^(WIDTH-1), divisor = -1): falls out naturally, quotient = -2^(WIDTH-1), remainder = 0, div_by_zero=0.
- Outputs register in FIX. In DONE, done=1 for exactly one cycle and busy=0.
- busy=1 in CALC and FIX only.
- Latency, counting the start-sampling edge as edge 0:
  - Normal: done high after edge WIDTH+2.
  - Divide by zero: done high after edge 2.
- Results and div_by_zero stay stable from done until the FIX of the next operation.
- Remainder sign always equals the dividend sign (truncating division); quotient rounds toward zero.

Test Plan:
- Unsigned 100/7, signed_op=0 -> done after edge 34, quotient=14, remainder=2, div_by_zero=0; busy high for exactly 33 cycles.
- Signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=-3, remainder=1.
- Divide by zero, dividend=0x1234, unsigned and signed -> done after edge 2, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Overflow 0x80000000 / 0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0, div_by_zero=0. Same operands unsigned -> quotient=0, remainder=0x80000000.
- start pulsed in CALC with new operands -> ignored, first result unchanged. Then start held high during DONE -> second operation accepted back-to-back, its done after a further 34 edges.
- rst_n dropped asynchronously mid-CALC (between edges) -> busy, done and outputs reach 0 immediately, no done pulse. After release, 9/3 yields quotient=3, remainder=0.
